mem_ctrl: RTL and testbench

Byte-wide main-memory controller sitting between the instruction-fetch unit (IC) and the load/store buffer (LSB). It latches single-cycle request pulses from both clients, arbitrates round-robin, and sequences each access as 1, 2 or 4 byte transfers on the 8-bit RAM/IO bus. It returns assembled little-endian data with a one-cycle ready pulse. An IC flush aborts instruction reads without disturbing LSB traffic.

---
 rtl/mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-wide RAM/IO controller arbitrating IC fetches and LSB loads/stores
// Requests are latched as pending, granted round-robin from IDLE, then sequenced one byte per cycle.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        ic_asking,
   input  logic [31:0] ic_addr,
   output logic [31:0] ic_data,
   output logic        data_ready,
   input  logic        lsb_req,
   input  logic        lsb_we,
   input  logic [31:0] lsb_addr,
   input  logic [1:0]  lsb_size,
   input  logic [31:0] lsb_wdata,
   output logic [31:0] lsb_rdata,
   output logic        lsb_ready,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);
   typedef enum logic [1:0] {IDLE, IC_READ, LSB_READ, LSB_WRITE} state_t;
   localparam logic GRANT_IC  = 1'b0;
   localparam logic GRANT_LSB = 1'b1;

   state_t      state, state_d;
   logic [2:0]  k, k_d, n, n_d;
   logic [31:0] base, base_d, wdata, wdata_d, rbuf, rbuf_d;
   logic        last_grant, last_grant_d;
   logic        ic_pend, ic_pend_d;
   logic [31:0] ic_addr_q, ic_addr_d;
   logic        lsb_pend, lsb_pend_d, lsb_we_q, lsb_we_d;
   logic [31:0] lsb_addr_q, lsb_addr_d, lsb_wdata_q, lsb_wdata_d;
   logic [1:0]  lsb_size_q, lsb_size_d;
   logic [31:0] ic_data_d, lsb_rdata_d, mem_a_d;
   logic        data_ready_d, lsb_ready_d, mem_wr_d;
   logic [7:0]  mem_dout_d;
   logic [31:0] wr_addr;

   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   always_comb begin
      state_d      = state;
      k_d          = k;
      n_d          = n;
      base_d       = base;
      wdata_d      = wdata;
      rbuf_d       = rbuf;
      last_grant_d = last_grant;
      ic_data_d    = ic_data;
      lsb_rdata_d  = lsb_rdata;
      data_ready_d = 1'b0;
      lsb_ready_d  = 1'b0;
      mem_a_d      = mem_a;
      mem_wr_d     = 1'b0;
      mem_dout_d   = 8'h00;
      wr_addr      = '0;

      // Requests sampled at this edge already count as pending for the IDLE grant below.
      ic_pend_d = ic_pend;
      ic_addr_d = ic_addr_q;
      if (flush) begin
         ic_pend_d = 1'b0;
      end else if (ic_asking && !ic_pend) begin
         ic_pend_d = 1'b1;
         ic_addr_d = ic_addr;
      end
      lsb_pend_d  = lsb_pend;
      lsb_we_d    = lsb_we_q;
      lsb_addr_d  = lsb_addr_q;
      lsb_size_d  = lsb_size_q;
      lsb_wdata_d = lsb_wdata_q;
      if (lsb_req && !lsb_pend) begin
         lsb_pend_d  = 1'b1;
         lsb_we_d    = lsb_we;
         lsb_addr_d  = lsb_addr;
         lsb_size_d  = lsb_size;
         lsb_wdata_d = lsb_wdata;
      end

      case (state)
         IDLE: begin
            mem_a_d = '0;
            if (ic_pend_d && (!lsb_pend_d || last_grant == GRANT_LSB)) begin
               ic_pend_d    = 1'b0;
               last_grant_d = GRANT_IC;
               base_d       = ic_addr_d;
               n_d          = 3'd4;
               k_d          = '0;
               rbuf_d       = '0;
               mem_a_d      = ic_addr_d;
               state_d      = IC_READ;
            end else if (lsb_pend_d) begin
               lsb_pend_d   = 1'b0;
               last_grant_d = GRANT_LSB;
               base_d       = lsb_addr_d;
               n_d          = nbytes(lsb_size_d);
               wdata_d      = lsb_wdata_d;
               k_d          = '0;
               rbuf_d       = '0;
               if (lsb_we_d) begin
                  state_d = LSB_WRITE;
               end else begin
                  state_d = LSB_READ;
                  mem_a_d = lsb_addr_d;
               end
            end
         end
         IC_READ, LSB_READ: begin
            rbuf_d = rbuf | ({24'h0, mem_din} << {k[1:0], 3'b000});
            if (state == IC_READ && flush) begin
               state_d = IDLE;
               mem_a_d = '0;
               k_d     = '0;
            end else if (k + 3'd1 == n) begin
               state_d = IDLE;
               mem_a_d = '0;
               k_d     = '0;
               if (state == IC_READ) begin
                  data_ready_d = 1'b1;
                  ic_data_d    = rbuf_d;
               end else begin
                  lsb_ready_d = 1'b1;
                  lsb_rdata_d = rbuf_d;
               end
            end else begin
               k_d     = k + 3'd1;
               mem_a_d = base + {29'h0, k_d};
            end
         end
         LSB_WRITE: begin
            if (k == n) begin
               state_d     = IDLE;
               mem_a_d     = '0;
               k_d         = '0;
               lsb_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // k counts bytes already issued; an IO-region byte waits while the IO buffer is full.
      if (state_d == LSB_WRITE) begin
         wr_addr = base_d + {29'h0, k_d};
         mem_a_d = wr_addr;
         if (!(wr_addr[17:16] == 2'b11 && io_buffer_full)) begin
            mem_wr_d = 1'b1;
            case (k_d[1:0])
               2'd0:    mem_dout_d = wdata_d[7:0];
               2'd1:    mem_dout_d = wdata_d[15:8];
               2'd2:    mem_dout_d = wdata_d[23:16];
               default: mem_dout_d = wdata_d[31:24];
            endcase
            k_d = k_d + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         k           <= '0;
         n           <= '0;
         base        <= '0;
         wdata       <= '0;
         rbuf        <= '0;
         last_grant  <= GRANT_IC;
         ic_pend     <= 1'b0;
         ic_addr_q   <= '0;
         lsb_pend    <= 1'b0;
         lsb_we_q    <= 1'b0;
         lsb_addr_q  <= '0;
         lsb_size_q  <= '0;
         lsb_wdata_q <= '0;
         ic_data     <= '0;
         lsb_rdata   <= '0;
         data_ready  <= 1'b0;
         lsb_ready   <= 1'b0;
         mem_a       <= '0;
         mem_wr      <= 1'b0;
         mem_dout    <= '0;
      end else begin
         state       <= state_d;
         k           <= k_d;
         n           <= n_d;
         base        <= base_d;
         wdata       <= wdata_d;
         rbuf        <= rbuf_d;
         last_grant  <= last_grant_d;
         ic_pend     <= ic_pend_d;
         ic_addr_q   <= ic_addr_d;
         lsb_pend    <= lsb_pend_d;
         lsb_we_q    <= lsb_we_d;
         lsb_addr_q  <= lsb_addr_d;
         lsb_size_q  <= lsb_size_d;
         lsb_wdata_q <= lsb_wdata_d;
         ic_data     <= ic_data_d;
         lsb_rdata   <= lsb_rdata_d;
         data_ready  <= data_ready_d;
         lsb_ready   <= lsb_ready_d;
         mem_a       <= mem_a_d;
         mem_wr      <= mem_wr_d;
         mem_dout    <= mem_dout_d;
      end
   end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - self-checking bench for mem_ctrl with a byte-array memory model
// Directed scenarios plus randomized traffic checked against a shadow memory.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst, flush, ic_asking, lsb_req, lsb_we, io_buffer_full;
   logic [31:0] ic_addr, lsb_addr, lsb_wdata;
   logic [1:0]  lsb_size;
   logic [7:0]  mem_din;
   logic [31:0] ic_data, lsb_rdata, mem_a;
   logic        data_ready, lsb_ready, mem_wr;
   logic [7:0]  mem_dout;

   int errors = 0;
   int checks = 0;

   logic [7:0] ram   [logic [31:0]];
   logic [7:0] model [logic [31:0]];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ic_asking(ic_asking), .ic_addr(ic_addr), .ic_data(ic_data), .data_ready(data_ready),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
      .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_ready(lsb_ready),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      return ram.exists(a) ? ram[a] : 8'h00;
   endfunction

   function automatic logic [7:0] model_rd(input logic [31:0] a);
      return model.exists(a) ? model[a] : 8'h00;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input int nb);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < nb; j++) r[8*j +: 8] = model_rd(a + 32'(j));
      return r;
   endfunction

   function automatic int size_bytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   task automatic model_store(input logic [31:0] a, input int nb, input logic [31:0] wd);
      for (int j = 0; j < nb; j++) model[a + 32'(j)] = wd[8*j +: 8];
   endtask

   task automatic preload(input logic [31:0] a, input logic [7:0] b);
      ram[a]   = b;
      model[a] = b;
   endtask

   // RAM: writes land at the sampled address; mem_din presents the byte at the address driven this cycle.
   always @(negedge clk) begin
      if (mem_wr === 1'b1) ram[mem_a] = mem_dout;
      mem_din = ((^mem_a) === 1'bx) ? 8'h00 : ram_rd(mem_a);
   end

   task automatic step();
      @(negedge clk);
      ic_asking = 1'b0;
      lsb_req   = 1'b0;
   endtask

   task automatic issue_ic(input logic [31:0] a);
      @(negedge clk);
      ic_asking = 1'b1;
      ic_addr   = a;
   endtask

   task automatic issue_lsb(input logic we, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      @(negedge clk);
      lsb_req   = 1'b1;
      lsb_we    = we;
      lsb_addr  = a;
      lsb_size  = sz;
      lsb_wdata = wd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; ic_asking = 1'b0; lsb_req = 1'b0; io_buffer_full = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input bit want_ic, input bit want_lsb, output int ic_t, output int lsb_t,
                            output logic [31:0] ic_got, output logic [31:0] lsb_got);
      ic_t = -1; lsb_t = -1; ic_got = '0; lsb_got = '0;
      for (int c = 1; c <= 60; c++) begin
         step();
         io_buffer_full = 1'($urandom_range(0, 1));
         if (data_ready === 1'b1) begin ic_t = c; ic_got = ic_data; end
         if (lsb_ready === 1'b1) begin lsb_t = c; lsb_got = lsb_rdata; end
         if ((!want_ic || ic_t >= 0) && (!want_lsb || lsb_t >= 0)) break;
      end
      io_buffer_full = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_a, mem_dout, mem_wr, data_ready, lsb_ready} !== 43'h0) begin
         errors++;
         $display("FAIL reset_bus: mem_a=%h dout=%h wr=%b dr=%b lr=%b, required all 0", mem_a, mem_dout, mem_wr, data_ready, lsb_ready);
      end
      checks++;
      if ({ic_data, lsb_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_data: ic_data=%h lsb_rdata=%h, required 0", ic_data, lsb_rdata);
      end
   endtask

   task automatic test_ic_fetch();
      preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h10); preload(32'h103, 8'h00);
      issue_ic(32'h100);
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if (mem_a !== 32'h100 + 32'(c - 1) || data_ready !== 1'b0 || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL ic_addr_seq c=%0d: mem_a=%h dr=%b wr=%b, required %h 0 0", c, mem_a, data_ready, mem_wr, 32'h100 + 32'(c - 1));
         end
      end
      step();
      checks++;
      if (data_ready !== 1'b1 || ic_data !== 32'h00100513 || mem_a !== 32'h0) begin
         errors++;
         $display("FAIL ic_ready: dr=%b ic_data=%h mem_a=%h, required 1 00100513 0", data_ready, ic_data, mem_a);
      end
      step();
      checks++;
      if (data_ready !== 1'b0 || ic_data !== 32'h00100513) begin
         errors++;
         $display("FAIL ic_pulse_hold: dr=%b ic_data=%h, required 0 00100513", data_ready, ic_data);
      end
   endtask

   task automatic test_half_load();
      preload(32'h2001, 8'hAB); preload(32'h2002, 8'hCD);
      issue_lsb(1'b0, 32'h2001, 2'b01, 32'h0);
      for (int c = 1; c <= 2; c++) begin
         step();
         checks++;
         if (mem_a !== 32'h2001 + 32'(c - 1) || lsb_ready !== 1'b0) begin
            errors++;
            $display("FAIL half_addr c=%0d: mem_a=%h lr=%b, required %h 0", c, mem_a, lsb_ready, 32'h2001 + 32'(c - 1));
         end
      end
      step();
      checks++;
      if (lsb_ready !== 1'b1 || lsb_rdata !== 32'h0000CDAB || data_ready !== 1'b0 || ic_data !== 32'h00100513) begin
         errors++;
         $display("FAIL half_load: lr=%b rdata=%h dr=%b ic_data=%h, required 1 0000cdab 0 00100513", lsb_ready, lsb_rdata, data_ready, ic_data);
      end
      step();
      checks++;
      if (lsb_ready !== 1'b0) begin
         errors++;
         $display("FAIL half_pulse: lr=%b, required 0", lsb_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w, exp_ic;
      w = 32'hDEADBEEF;
      do_reset();
      for (int i = 0; i < 4; i++) preload(32'h500 + 32'(i), 8'($urandom));
      exp_ic = model_load(32'h500, 4);
      model_store(32'h400, 4, w);
      issue_lsb(1'b1, 32'h400, 2'b10, w);
      ic_asking = 1'b1;
      ic_addr   = 32'h500;
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if (mem_wr !== 1'b1 || mem_a !== 32'h400 + 32'(c - 1) || mem_dout !== w[8*(c-1) +: 8]) begin
            errors++;
            $display("FAIL b2b_write c=%0d: wr=%b a=%h d=%h, required 1 %h %h", c, mem_wr, mem_a, mem_dout, 32'h400 + 32'(c - 1), w[8*(c-1) +: 8]);
         end
      end
      step();
      checks++;
      if (lsb_ready !== 1'b1 || mem_wr !== 1'b0 || data_ready !== 1'b0 || mem_a !== 32'h0) begin
         errors++;
         $display("FAIL b2b_store_done: lr=%b wr=%b dr=%b a=%h, required 1 0 0 0", lsb_ready, mem_wr, data_ready, mem_a);
      end
      for (int c = 6; c <= 9; c++) begin
         step();
         checks++;
         if (mem_a !== 32'h500 + 32'(c - 6) || mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ic_addr c=%0d: a=%h wr=%b, required %h 0", c, mem_a, mem_wr, 32'h500 + 32'(c - 6));
         end
      end
      step();
      checks++;
      if (data_ready !== 1'b1 || ic_data !== exp_ic) begin
         errors++;
         $display("FAIL b2b_ic_data: dr=%b ic_data=%h, required 1 %h", data_ready, ic_data, exp_ic);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ram_rd(32'h400 + 32'(i)) !== model_rd(32'h400 + 32'(i))) begin
            errors++;
            $display("FAIL b2b_ram i=%0d: got %h, required %h", i, ram_rd(32'h400 + 32'(i)), model_rd(32'h400 + 32'(i)));
         end
      end
   endtask

   task automatic test_flush();
      int ic_t, lsb_t;
      logic [31:0] ic_got, lsb_got, exp_ic;
      bit seen;
      issue_ic(32'h600);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (mem_a !== 32'h0 || data_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_abort: a=%h dr=%b, required 0 0", mem_a, data_ready);
      end
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (data_ready !== 1'b0 || mem_a !== 32'h0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_quiet: activity after flush observed=1, required 0");
      end
      for (int i = 0; i < 4; i++) preload(32'h200 + 32'(i), 8'($urandom));
      exp_ic = model_load(32'h200, 4);
      issue_ic(32'h200);
      wait_done(1'b1, 1'b0, ic_t, lsb_t, ic_got, lsb_got);
      checks++;
      if (ic_t !== 5 || ic_got !== exp_ic) begin
         errors++;
         $display("FAIL flush_refetch: lat=%0d data=%h, required 5 %h", ic_t, ic_got, exp_ic);
      end
   endtask

   task automatic test_io_stall();
      issue_lsb(1'b1, 32'h30000, 2'b00, 32'h41);
      io_buffer_full = 1'b1;
      model_store(32'h30000, 1, 32'h41);
      for (int c = 1; c <= 3; c++) begin
         step();
         if (c == 3) io_buffer_full = 1'b0;
         checks++;
         if (mem_wr !== 1'b0 || lsb_ready !== 1'b0) begin
            errors++;
            $display("FAIL io_stall c=%0d: wr=%b lr=%b, required 0 0", c, mem_wr, lsb_ready);
         end
      end
      step();
      checks++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41) begin
         errors++;
         $display("FAIL io_write: wr=%b a=%h d=%h, required 1 00030000 41", mem_wr, mem_a, mem_dout);
      end
      step();
      checks++;
      if (lsb_ready !== 1'b1 || mem_wr !== 1'b0 || ram_rd(32'h30000) !== 8'h41) begin
         errors++;
         $display("FAIL io_done: lr=%b wr=%b ram=%h, required 1 0 41", lsb_ready, mem_wr, ram_rd(32'h30000));
      end
      issue_lsb(1'b1, 32'h20000, 2'b00, 32'h5A);
      io_buffer_full = 1'b1;
      step();
      checks++;
      if (mem_wr !== 1'b1 || mem_a !== 32'h20000 || mem_dout !== 8'h5A) begin
         errors++;
         $display("FAIL non_io_no_stall: wr=%b a=%h d=%h, required 1 00020000 5a", mem_wr, mem_a, mem_dout);
      end
      step();
      io_buffer_full = 1'b0;
      checks++;
      if (lsb_ready !== 1'b1) begin
         errors++;
         $display("FAIL non_io_done: lr=%b, required 1", lsb_ready);
      end
   endtask

   task automatic test_wrap();
      preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22); preload(32'h0, 8'h33); preload(32'h1, 8'h44);
      issue_lsb(1'b0, 32'hFFFFFFFE, 2'b10, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++;
         if (mem_a !== 32'hFFFFFFFE + 32'(c - 1)) begin
            errors++;
            $display("FAIL wrap_addr c=%0d: a=%h, required %h", c, mem_a, 32'hFFFFFFFE + 32'(c - 1));
         end
      end
      step();
      checks++;
      if (lsb_ready !== 1'b1 || lsb_rdata !== 32'h44332211) begin
         errors++;
         $display("FAIL wrap_data: lr=%b rdata=%h, required 1 44332211", lsb_ready, lsb_rdata);
      end
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      issue_lsb(1'b1, 32'h700, 2'b10, 32'h12345678);
      step();
      ic_asking = 1'b1;
      ic_addr   = 32'h800;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({mem_a, mem_dout, mem_wr, data_ready, lsb_ready, ic_data, lsb_rdata} !== 107'h0) begin
         errors++;
         $display("FAIL rst_mid_write: a=%h d=%h wr=%b dr=%b lr=%b ic=%h lsb=%h, required all 0",
                  mem_a, mem_dout, mem_wr, data_ready, lsb_ready, ic_data, lsb_rdata);
      end
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (data_ready !== 1'b0 || lsb_ready !== 1'b0 || mem_a !== 32'h0 || mem_wr !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rst_pending_cleared: activity after reset observed=1, required 0");
      end
   endtask

   task automatic test_random();
      int ic_t, lsb_t, kind, nb, exp_ic_t, exp_lsb_t;
      logic [31:0] ic_got, lsb_got, exp_ic, exp_lsb, ia, la, wd, last_load;
      logic [1:0] sz;
      logic we, lg_lsb, lsb_first;
      do_reset();
      lg_lsb = 1'b0;
      last_load = '0;
      for (int i = 0; i < 128; i++) preload(32'h1000 + 32'(i), 8'($urandom));
      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 2);
         ia = 32'h1000 + 32'($urandom_range(0, 31)) * 32'd2;
         la = 32'h1000 + 32'($urandom_range(0, 63));
         sz = 2'($urandom_range(0, 3));
         we = 1'($urandom_range(0, 1));
         wd = $urandom;
         nb = size_bytes(sz);
         lsb_first = (kind == 1) || (kind == 2 && !lg_lsb);
         exp_ic = '0;
         if (kind != 1 && !lsb_first) exp_ic = model_load(ia, 4);
         if (kind != 0) begin
            if (we) model_store(la, nb, wd);
            else last_load = model_load(la, nb);
            exp_lsb = last_load;
         end else begin
            exp_lsb = '0;
         end
         if (kind != 1 && lsb_first) exp_ic = model_load(ia, 4);
         if (kind == 0) begin
            issue_ic(ia);
         end else begin
            issue_lsb(we, la, sz, wd);
            if (kind == 2) begin
               ic_asking = 1'b1;
               ic_addr   = ia;
            end
         end
         wait_done(kind != 1, kind != 0, ic_t, lsb_t, ic_got, lsb_got);
         exp_ic_t  = (kind == 0) ? 5 : (lsb_first ? nb + 6 : 5);
         exp_lsb_t = (kind == 1) ? nb + 1 : (lsb_first ? nb + 1 : nb + 6);
         if (kind != 1) begin
            checks++;
            if (ic_t !== exp_ic_t || ic_got !== exp_ic) begin
               errors++;
               $display("FAIL rand_ic it=%0d: lat=%0d data=%h, required %0d %h", it, ic_t, ic_got, exp_ic_t, exp_ic);
            end
            lg_lsb = 1'b0;
         end
         if (kind != 0) begin
            checks++;
            if (lsb_t !== exp_lsb_t || lsb_got !== exp_lsb) begin
               errors++;
               $display("FAIL rand_lsb it=%0d we=%b sz=%0d: lat=%0d data=%h, required %0d %h", it, we, sz, lsb_t, lsb_got, exp_lsb_t, exp_lsb);
            end
            if (kind == 1 || !lsb_first) lg_lsb = 1'b1;
         end
      end
      for (int i = 0; i < 72; i++) begin
         checks++;
         if (ram_rd(32'h1000 + 32'(i)) !== model_rd(32'h1000 + 32'(i))) begin
            errors++;
            $display("FAIL rand_mem addr=%h: got %h, required %h", 32'h1000 + 32'(i), ram_rd(32'h1000 + 32'(i)), model_rd(32'h1000 + 32'(i)));
         end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; ic_asking = 1'b0; ic_addr = '0; lsb_req = 1'b0; lsb_we = 1'b0;
      lsb_addr = '0; lsb_size = '0; lsb_wdata = '0; io_buffer_full = 1'b0;
      test_reset();
      test_ic_fetch();
      test_half_load();
      test_back_to_back();
      test_flush();
      test_io_stall();
      test_wrap();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
